// File: rtl/pre_if_stage_mw.sv
// Pre-IF PC generator for a multi-issue front end: picks the next fetch-group PC,
// arbitrates redirects and drives the ICache request for the group.
module pre_if_stage_mw #(
    parameter int unsigned FETCH_WIDTH = 2,
    parameter int unsigned LINE_BYTES  = 16,
    parameter logic [31:0] RESET_PC    = 32'hbfc00000,
    localparam int unsigned SlotW      = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   fs_allowin,
    input  logic                   icache_busy,
    input  logic                   eret,
    input  logic [31:0]            epc,
    input  logic                   flush,
    input  logic [31:0]            exc_addr,
    input  logic                   refetch,
    input  logic [31:0]            refetch_pc,
    input  logic                   br_mispredict,
    input  logic [31:0]            br_correct_pc,
    input  logic                   bpu_valid,
    input  logic [SlotW-1:0]       bpu_slot,
    input  logic [31:0]            bpu_target,
    input  logic [19:0]            tlb_pfn,
    input  logic                   tlb_ex,
    input  logic [4:0]             tlb_exctype,
    input  logic                   tlb_stall,
    input  logic                   cacheop,
    input  logic [7:0]             cacheop_index,
    output logic [31:0]            ps_pc,
    output logic                   ps_valid,
    output logic [FETCH_WIDTH-1:0] ps_mask,
    output logic                   ps_ex,
    output logic [4:0]             ps_exctype,
    output logic                   ic_req,
    output logic [7:0]             ic_index,
    output logic [19:0]            ic_tag,
    output logic [3:0]             ic_offset
);

    // A group never spans an ICache line.
    localparam int unsigned GroupBytes =
        (LINE_BYTES < FETCH_WIDTH * 4) ? LINE_BYTES : FETCH_WIDTH * 4;
    localparam logic [SlotW-1:0] SlotMask  = SlotW'(GroupBytes / 4 - 1);
    localparam logic [31:0]      GroupMask = 32'(GroupBytes - 1);
    localparam logic [4:0]       ExcAdel   = 5'h04;

    typedef enum logic [1:0] {StRun, StDrain, StCacheop} state_e;

    state_e            state_q;
    logic [31:0]       ps_pc_q, ps_pc_d;
    logic              live_q, refetch_pend_q, cop_pend_q;
    logic [7:0]        cop_index_q;

    logic              adv, redirect, is_refetch, adel, exc;
    logic [SlotW-1:0]  s0;
    logic [31:0]       group_end, redirect_pc;

    assign s0         = ps_pc_q[SlotW+1:2] & SlotMask;
    assign group_end  = (ps_pc_q & ~GroupMask) + 32'(GroupBytes);
    assign redirect   = eret | flush | br_mispredict;
    assign is_refetch = flush & refetch & ~eret;
    assign adel       = ps_pc_q[1:0] != 2'b00;
    assign exc        = adel | tlb_ex;
    assign adv        = ps_valid & fs_allowin;

    always_comb begin
        if (eret)                 redirect_pc = epc;
        else if (flush & refetch) redirect_pc = refetch_pc;
        else if (flush)           redirect_pc = exc_addr;
        else                      redirect_pc = br_correct_pc;
    end

    // Hard redirects land regardless of handshake; sequential flow waits for adv.
    always_comb begin
        ps_pc_d = ps_pc_q;
        if (redirect)  ps_pc_d = redirect_pc;
        else if (adv)  ps_pc_d = bpu_valid ? bpu_target : group_end;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= StRun;
            ps_pc_q        <= RESET_PC;
            live_q         <= 1'b0;
            refetch_pend_q <= 1'b0;
            cop_pend_q     <= 1'b0;
            cop_index_q    <= 8'h00;
        end else begin
            live_q  <= 1'b1;
            ps_pc_q <= ps_pc_d;
            if (cacheop) begin
                cop_pend_q  <= 1'b1;
                cop_index_q <= cacheop_index;
            end
            case (state_q)
                StRun: begin
                    if (icache_busy && (flush || eret)) begin
                        state_q        <= StDrain;
                        refetch_pend_q <= is_refetch;
                    end else if (cacheop || cop_pend_q) begin
                        state_q <= StCacheop;
                    end
                end
                StDrain: begin
                    if (!icache_busy) begin
                        state_q        <= StRun;
                        refetch_pend_q <= 1'b0;
                    end else if (redirect) begin
                        refetch_pend_q <= is_refetch;
                    end
                end
                StCacheop: begin
                    if (!icache_busy) begin
                        state_q <= StRun;
                        if (!cacheop) cop_pend_q <= 1'b0;
                    end
                end
                default: state_q <= StRun;
            endcase
        end
    end

    always_comb begin
        ps_valid = 1'b0;
        ic_req   = 1'b0;
        ic_index = ps_pc_q[11:4];
        case (state_q)
            StRun:     ps_valid = live_q & ~icache_busy & ~tlb_stall;
            // Exit cycle of a drain offers the group unless a refetch caused it.
            StDrain:   ps_valid = live_q & ~icache_busy & ~tlb_stall & ~refetch_pend_q;
            StCacheop: begin
                ic_index = cop_index_q;
                ic_req   = live_q & ~icache_busy;
            end
            default: ;
        endcase
        if (ps_valid && !exc) ic_req = 1'b1;

        ps_mask = '0;
        if (ps_valid && !redirect) begin
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                if (exc) ps_mask[i] = (SlotW'(i) == s0);
                else     ps_mask[i] = (SlotW'(i) >= s0) && (!bpu_valid || SlotW'(i) <= bpu_slot);
            end
        end

        ps_ex      = ps_valid & exc;
        ps_exctype = ps_ex ? (adel ? ExcAdel : tlb_exctype) : 5'h00;
    end

    assign ps_pc     = ps_pc_q;
    assign ic_tag    = tlb_pfn;
    assign ic_offset = ps_pc_q[3:0];

endmodule

// File: tb/tb_pre_if_stage_mw.sv
// Bench for pre_if_stage_mw: directed scenarios plus a randomized run against a
// behavioural model of the fetch-group rules.
module tb_pre_if_stage_mw;

    localparam logic [31:0] RST_PC = 32'hbfc00000;

    logic        clk, resetn, fs_allowin, icache_busy;
    logic        eret, flush, refetch, br_mispredict, bpu_valid;
    logic [31:0] epc, exc_addr, refetch_pc, br_correct_pc, bpu_target;
    logic [0:0]  bpu_slot;
    logic [19:0] tlb_pfn;
    logic        tlb_ex, tlb_stall, cacheop;
    logic [4:0]  tlb_exctype;
    logic [7:0]  cacheop_index;
    logic [31:0] ps_pc;
    logic        ps_valid, ps_ex, ic_req;
    logic [1:0]  ps_mask;
    logic [4:0]  ps_exctype;
    logic [7:0]  ic_index;
    logic [19:0] ic_tag;
    logic [3:0]  ic_offset;

    int errors = 0;
    int checks = 0;

    pre_if_stage_mw #(.FETCH_WIDTH(2), .LINE_BYTES(16), .RESET_PC(RST_PC)) dut (
        .clk(clk), .resetn(resetn), .fs_allowin(fs_allowin), .icache_busy(icache_busy),
        .eret(eret), .epc(epc), .flush(flush), .exc_addr(exc_addr), .refetch(refetch),
        .refetch_pc(refetch_pc), .br_mispredict(br_mispredict), .br_correct_pc(br_correct_pc),
        .bpu_valid(bpu_valid), .bpu_slot(bpu_slot), .bpu_target(bpu_target),
        .tlb_pfn(tlb_pfn), .tlb_ex(tlb_ex), .tlb_exctype(tlb_exctype), .tlb_stall(tlb_stall),
        .cacheop(cacheop), .cacheop_index(cacheop_index), .ps_pc(ps_pc), .ps_valid(ps_valid),
        .ps_mask(ps_mask), .ps_ex(ps_ex), .ps_exctype(ps_exctype), .ic_req(ic_req),
        .ic_index(ic_index), .ic_tag(ic_tag), .ic_offset(ic_offset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        fs_allowin = 1'b1; icache_busy = 1'b0; eret = 1'b0; flush = 1'b0; refetch = 1'b0;
        br_mispredict = 1'b0; bpu_valid = 1'b0; bpu_slot = 1'b0; tlb_ex = 1'b0;
        tlb_stall = 1'b0; cacheop = 1'b0; tlb_exctype = 5'h00; cacheop_index = 8'h00;
        epc = '0; exc_addr = '0; refetch_pc = '0; br_correct_pc = '0; bpu_target = '0;
        tlb_pfn = 20'h12345;
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        br_mispredict = 1'b1; br_correct_pc = pc;
        tick();
        br_mispredict = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        checks++; if (ps_pc !== RST_PC) begin errors++; $display("FAIL reset_pc got %h want %h", ps_pc, RST_PC); end
        checks++; if (ps_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", ps_valid); end
        checks++; if (ps_mask !== 2'b00) begin errors++; $display("FAIL reset_mask got %b want 00", ps_mask); end
        checks++; if (ps_ex !== 1'b0) begin errors++; $display("FAIL reset_ex got %b want 0", ps_ex); end
        checks++; if (ic_req !== 1'b0) begin errors++; $display("FAIL reset_icreq got %b want 0", ic_req); end
    endtask

    task automatic test_stream();
        logic [31:0] want;
        for (int k = 0; k < 3; k++) begin
            want = RST_PC + 32'(8 * k);
            checks++; if (ps_pc !== want) begin errors++; $display("FAIL stream_pc got %h want %h", ps_pc, want); end
            checks++; if (ps_mask !== 2'b11) begin errors++; $display("FAIL stream_mask got %b want 11", ps_mask); end
            tick();
        end
    endtask

    task automatic test_unaligned();
        br_mispredict = 1'b1; br_correct_pc = 32'h1004;
        #1;
        checks++; if (ps_mask !== 2'b00) begin errors++; $display("FAIL squash_mask got %b want 00", ps_mask); end
        tick();
        br_mispredict = 1'b0;
        #1;
        checks++; if (ps_pc !== 32'h1004) begin errors++; $display("FAIL unal_pc got %h want 1004", ps_pc); end
        checks++; if (ps_mask !== 2'b10) begin errors++; $display("FAIL unal_mask got %b want 10", ps_mask); end
        tick();
        checks++; if (ps_pc !== 32'h1008) begin errors++; $display("FAIL unal_next got %h want 1008", ps_pc); end
    endtask

    task automatic test_bpu();
        redirect_to(32'h1000);
        bpu_valid = 1'b1; bpu_slot = 1'b0; bpu_target = 32'h2000;
        #1;
        checks++; if (ps_mask !== 2'b01) begin errors++; $display("FAIL bpu_mask got %b want 01", ps_mask); end
        tick();
        bpu_valid = 1'b0;
        #1;
        checks++; if (ps_pc !== 32'h2000) begin errors++; $display("FAIL bpu_pc got %h want 2000", ps_pc); end
    endtask

    task automatic test_flush_busy();
        icache_busy = 1'b1; flush = 1'b1; exc_addr = 32'hbfc00380;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (ps_valid !== 1'b0) begin errors++; $display("FAIL drain_valid cyc %0d got %b want 0", k, ps_valid); end
            tick();
            flush = 1'b0;
        end
        icache_busy = 1'b0;
        #1;
        checks++; if (ps_valid !== 1'b1) begin errors++; $display("FAIL drain_exit_valid got %b want 1", ps_valid); end
        checks++; if (ps_pc !== 32'hbfc00380) begin errors++; $display("FAIL drain_pc got %h want bfc00380", ps_pc); end
        tick();
        // eret while draining overrides the exception target
        icache_busy = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0; eret = 1'b1; epc = 32'h3000;
        #1;
        checks++; if (ps_valid !== 1'b0) begin errors++; $display("FAIL eret_valid got %b want 0", ps_valid); end
        tick();
        eret = 1'b0;
        tick();
        icache_busy = 1'b0;
        #1;
        checks++; if (ps_pc !== 32'h3000) begin errors++; $display("FAIL eret_pc got %h want 3000", ps_pc); end
        checks++; if (ps_valid !== 1'b1) begin errors++; $display("FAIL eret_exit_valid got %b want 1", ps_valid); end
        tick();
        // refetch while busy: exit group withheld, offered the cycle after
        icache_busy = 1'b1; flush = 1'b1; refetch = 1'b1; refetch_pc = 32'h5000;
        tick();
        flush = 1'b0; refetch = 1'b0; icache_busy = 1'b0;
        #1;
        checks++; if (ps_valid !== 1'b0) begin errors++; $display("FAIL refetch_exit_valid got %b want 0", ps_valid); end
        tick();
        checks++; if (ps_valid !== 1'b1 || ps_pc !== 32'h5000) begin
            errors++; $display("FAIL refetch_resume got valid %b pc %h want 1 5000", ps_valid, ps_pc);
        end
    endtask

    task automatic test_adel();
        flush = 1'b1; refetch = 1'b1; refetch_pc = 32'h1002;
        tick();
        flush = 1'b0; refetch = 1'b0;
        #1;
        checks++; if (ps_ex !== 1'b1) begin errors++; $display("FAIL adel_ex got %b want 1", ps_ex); end
        checks++; if (ps_exctype !== 5'h04) begin errors++; $display("FAIL adel_code got %h want 04", ps_exctype); end
        checks++; if (ic_req !== 1'b0) begin errors++; $display("FAIL adel_icreq got %b want 0", ic_req); end
        checks++; if (ps_mask !== 2'b01) begin errors++; $display("FAIL adel_mask got %b want 01", ps_mask); end
        redirect_to(32'h2000);
    endtask

    task automatic test_wrap();
        redirect_to(32'hFFFFFFF8);
        tick();
        checks++; if (ps_pc !== 32'h0) begin errors++; $display("FAIL wrap8_pc got %h want 0", ps_pc); end
        redirect_to(32'hFFFFFFFC);
        checks++; if (ps_mask !== 2'b10) begin errors++; $display("FAIL wrapc_mask got %b want 10", ps_mask); end
        tick();
        checks++; if (ps_pc !== 32'h0) begin errors++; $display("FAIL wrapc_pc got %h want 0", ps_pc); end
    endtask

    task automatic test_cacheop();
        redirect_to(32'h4000);
        fs_allowin = 1'b0; cacheop = 1'b1; cacheop_index = 8'h5A;
        tick();
        cacheop = 1'b0;
        #1;
        checks++; if (ic_index !== 8'h5A) begin errors++; $display("FAIL cop_index got %h want 5a", ic_index); end
        checks++; if (ps_valid !== 1'b0) begin errors++; $display("FAIL cop_valid got %b want 0", ps_valid); end
        tick();
        checks++; if (ps_valid !== 1'b1 || ps_pc !== 32'h4000) begin
            errors++; $display("FAIL cop_resume got valid %b pc %h want 1 4000", ps_valid, ps_pc);
        end
        checks++; if (ic_index !== 8'h00) begin errors++; $display("FAIL cop_after_index got %h want 00", ic_index); end
        fs_allowin = 1'b1;
    endtask

    task automatic test_reset_mid();
        icache_busy = 1'b1; flush = 1'b1; exc_addr = 32'hbfc00380;
        tick();
        flush = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        checks++; if (ps_pc !== RST_PC || ps_valid !== 1'b0) begin
            errors++; $display("FAIL midreset got pc %h valid %b want %h 0", ps_pc, ps_valid, RST_PC);
        end
        resetn = 1'b1; icache_busy = 1'b0;
        tick();
        checks++; if (ps_pc !== RST_PC || ps_valid !== 1'b1) begin
            errors++; $display("FAIL midreset_resume got pc %h valid %b want %h 1", ps_pc, ps_valid, RST_PC);
        end
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] r;
        r = $urandom;
        r[1:0] = ($urandom_range(0, 9) == 0) ? 2'b10 : 2'b00;
        return r;
    endfunction

    task automatic test_random();
        // Model: PC, what the front end is waiting on, and the latched cacheop.
        logic [31:0] m_pc, want_pc;
        logic [7:0]  m_cidx, want_idx;
        logic [1:0]  want_mask;
        logic [4:0]  want_code;
        bit          m_live, waiting_drain, waiting_cop, drain_by_refetch, cop_owed;
        bit          offer, bad_align, has_exc, hard_redir;
        int          first;

        idle();
        resetn = 1'b0;
        #2;
        resetn = 1'b1;
        m_pc = RST_PC; m_live = 0; waiting_drain = 0; waiting_cop = 0;
        drain_by_refetch = 0; cop_owed = 0; m_cidx = 8'h00;
        for (int c = 0; c < 400; c++) begin
            icache_busy   = ($urandom_range(0, 99) < 30);
            fs_allowin    = ($urandom_range(0, 99) < 75);
            eret          = ($urandom_range(0, 99) < 3);
            flush         = ($urandom_range(0, 99) < 6);
            refetch       = $urandom_range(0, 1);
            br_mispredict = ($urandom_range(0, 99) < 6);
            bpu_valid     = ($urandom_range(0, 99) < 25);
            bpu_slot      = 1'($urandom_range(0, 1));
            epc = rand_pc(); exc_addr = rand_pc(); refetch_pc = rand_pc();
            br_correct_pc = rand_pc(); bpu_target = rand_pc();
            tlb_pfn = 20'($urandom); tlb_ex = ($urandom_range(0, 99) < 5);
            tlb_exctype = 5'($urandom); tlb_stall = ($urandom_range(0, 99) < 10);
            cacheop = ($urandom_range(0, 99) < 4); cacheop_index = 8'($urandom);
            #1;

            offer = m_live && !icache_busy && !tlb_stall && !waiting_cop &&
                    !(waiting_drain && drain_by_refetch);
            bad_align  = (m_pc % 4) != 0;
            has_exc    = bad_align || tlb_ex;
            hard_redir = eret || flush || br_mispredict;
            first      = (m_pc / 4) % 2;
            want_mask  = 2'b00;
            if (offer && !hard_redir) begin
                if (has_exc) want_mask[first] = 1'b1;
                else for (int i = first; i < 2; i++)
                    if (!bpu_valid || i <= int'(bpu_slot)) want_mask[i] = 1'b1;
            end
            want_idx  = waiting_cop ? m_cidx : m_pc[11:4];
            want_code = bad_align ? 5'h04 : tlb_exctype;

            checks++; if (ps_pc !== m_pc) begin errors++; $display("FAIL rnd_pc cyc %0d got %h want %h", c, ps_pc, m_pc); end
            checks++; if (ps_valid !== offer) begin errors++; $display("FAIL rnd_valid cyc %0d got %b want %b", c, ps_valid, offer); end
            checks++; if (ps_mask !== want_mask) begin errors++; $display("FAIL rnd_mask cyc %0d got %b want %b", c, ps_mask, want_mask); end
            checks++; if (ps_ex !== (offer && has_exc)) begin errors++; $display("FAIL rnd_ex cyc %0d got %b want %b", c, ps_ex, offer && has_exc); end
            checks++; if (ic_index !== want_idx) begin errors++; $display("FAIL rnd_index cyc %0d got %h want %h", c, ic_index, want_idx); end
            if (!waiting_cop) begin
                checks++; if (ic_req !== (offer && !has_exc)) begin errors++; $display("FAIL rnd_icreq cyc %0d got %b want %b", c, ic_req, offer && !has_exc); end
            end
            if (offer && has_exc) begin
                checks++; if (ps_exctype !== want_code) begin errors++; $display("FAIL rnd_code cyc %0d got %h want %h", c, ps_exctype, want_code); end
            end

            if (eret)                     want_pc = epc;
            else if (flush && refetch)    want_pc = refetch_pc;
            else if (flush)               want_pc = exc_addr;
            else if (br_mispredict)       want_pc = br_correct_pc;
            else if (offer && fs_allowin) want_pc = bpu_valid ? bpu_target : m_pc - (m_pc % 8) + 32'd8;
            else                          want_pc = m_pc;

            if (waiting_drain) begin
                if (!icache_busy) begin waiting_drain = 0; drain_by_refetch = 0; end
                else if (hard_redir) drain_by_refetch = flush && refetch && !eret;
            end else if (waiting_cop) begin
                if (!icache_busy) begin waiting_cop = 0; if (!cacheop) cop_owed = 0; end
            end else if (icache_busy && (flush || eret)) begin
                waiting_drain = 1; drain_by_refetch = flush && refetch && !eret;
            end else if (cacheop || cop_owed) begin
                waiting_cop = 1;
            end
            if (cacheop) begin cop_owed = 1; m_cidx = cacheop_index; end
            m_pc = want_pc;
            m_live = 1;
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        resetn = 1'b1;
        tick();
        test_stream();
        test_unaligned();
        test_bpu();
        test_flush_busy();
        test_adel();
        test_wrap();
        test_cacheop();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
